// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared types and defaults for the key debouncer.
//   key_state_e     per-channel FSM state (UP, WAIT_DOWN, DOWN, WAIT_UP)
//   DEF_*           default timing constants in CLK cycles
//   is_pressed()    debounced level decoded from an FSM state
package key_debounce_pkg;

  // Encoding chosen so that bit 1 alone is the debounced level: the
  // decoded KEY_STATE comes from a single flop and cannot glitch.
  typedef enum logic [1:0] {
    UP        = 2'b00,
    WAIT_DOWN = 2'b01,
    DOWN      = 2'b10,
    WAIT_UP   = 2'b11
  } key_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500_000;     // 10 ms at 50 MHz
  localparam int unsigned DEF_REPEAT_DELAY    = 25_000_000;  // 500 ms at 50 MHz
  localparam int unsigned DEF_REPEAT_PERIOD   = 5_000_000;   // 100 ms at 50 MHz

  function automatic logic is_pressed(input key_state_e s);
    return s[1];
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one debounced key channel.
//   clk        system clock
//   rst_n      asynchronous active-low reset (externally synchronized release)
//   key_n      raw key level, active-low, asynchronous to clk
//   state_o    FSM state (debounced level is state_o[1])
//   press_o    one-cycle pulse on debounced press (and on auto-repeat)
//   release_o  one-cycle pulse on debounced release
// Optional feature: define KEY_DEBOUNCE_REPEAT_EN to enable auto-repeat.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef KEY_DEBOUNCE_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
  output key_state_e state_o,
  output logic       press_o,
  output logic       release_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             key_s;
  logic             rpt_fire;

  // Two-flop synchronizer; flops idle at 1 (released).
  assign sync_d = {sync_q[0], key_n};
  assign key_s  = sync_q[1];

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_armed_q, rpt_armed_d;

  // Counts only while DOWN and still held; any other cycle clears it, so
  // the first repeat is always measured from the latest entry into DOWN.
  // rpt_armed_q selects the first delay versus the steady repeat period.
  always_comb begin
    rpt_cnt_d   = '0;
    rpt_armed_d = 1'b0;
    rpt_fire    = 1'b0;
    if (state_q == DOWN && !key_s) begin
      if (rpt_cnt_q == (rpt_armed_q ? RPT_NEXT : RPT_FIRST)) begin
        rpt_fire    = 1'b1;
        rpt_armed_d = 1'b1;
      end else begin
        rpt_cnt_d   = rpt_cnt_q + 1'b1;
        rpt_armed_d = rpt_armed_q;
      end
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      UP: begin
        if (!key_s) begin
          state_d = WAIT_DOWN;
          cnt_d   = '0;
        end
      end
      WAIT_DOWN: begin
        if (key_s) begin
          state_d = UP;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DOWN;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DOWN: begin
        if (key_s) begin
          state_d = WAIT_UP;
          cnt_d   = '0;
        end
      end
      WAIT_UP: begin
        if (!key_s) begin
          state_d = DOWN;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = UP;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = UP;
    endcase
    // Repeats fire only in DOWN, releases only leaving WAIT_UP: never together.
    press_d = press_d | rpt_fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 2'b11;
      state_q     <= UP;
      cnt_q       <= '0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
`endif
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      press_q     <= press_d;
      release_q   <= release_d;
`ifdef KEY_DEBOUNCE_REPEAT_EN
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_armed_q <= rpt_armed_d;
`endif
    end
  end

  assign state_o   = state_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/key_debounce.sv
// key_debounce: N_KEYS independent push-button debouncers.
//   CLK          system clock (only clock)
//   RST          asynchronous active-low reset; release must already be
//                synchronized to CLK
//   KEY          raw key levels, active-low, asynchronous
//   KEY_STATE    debounced levels, active-high
//   KEY_PRESS    one-CLK pulse per debounced press (plus repeats if enabled)
//   KEY_RELEASE  one-CLK pulse per debounced release
// Output protocol: PRESS/RELEASE are single-cycle event strobes with no
// back-pressure; a consumer must sample them on every CLK edge. PRESS and
// RELEASE of one channel are never high together; channels may coincide.
// Optional feature: define KEY_DEBOUNCE_REPEAT_EN to enable auto-repeat.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned N_KEYS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] KEY_STATE,
  output logic [N_KEYS-1:0] KEY_PRESS,
  output logic [N_KEYS-1:0] KEY_RELEASE
);

  // Range check on the timing parameters; the block is empty and only
  // appears in the elaborated hierarchy for an illegal configuration.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_illegal_config
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_state_e ch_state;

    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef KEY_DEBOUNCE_REPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk      (CLK),
      .rst_n    (RST),
      .key_n    (KEY[i]),
      .state_o  (ch_state),
      .press_o  (KEY_PRESS[i]),
      .release_o(KEY_RELEASE[i])
    );

    assign KEY_STATE[i] = is_pressed(ch_state);
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed bench for key_debounce with DEBOUNCE_CYCLES=8,
// REPEAT_DELAY=20, REPEAT_PERIOD=6. Edge k is the k-th rising CLK edge;
// inputs change shortly after edge k-1 so they are first sampled at edge k.
module tb_key_debounce;

  localparam int NK  = 4;
  localparam int DB  = 8;
  localparam int RD  = 20;
  localparam int RP  = 6;
  localparam int LAT = DB + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NK-1:0] key = '1;
  logic [NK-1:0] key_state, key_press, key_release;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  // {cycle[31:0], press[3:0], release[3:0]}
  logic [39:0] exp_q[$];
  // {cycle[31:0], key_state[3:0]}
  logic [35:0] st_q[$];

  key_debounce #(
    .N_KEYS         (NK),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .KEY        (key),
    .KEY_STATE  (key_state),
    .KEY_PRESS  (key_press),
    .KEY_RELEASE(key_release)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  // Return just after edge c-1, so anything driven is first sampled at edge c.
  task automatic goto(input int c);
    while (cyc < c - 1) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic exp_pulse(input int c, input logic [3:0] p, input logic [3:0] r);
    exp_q.push_back({32'(c), p, r});
  endtask

  task automatic exp_state(input int c, input logic [3:0] s);
    st_q.push_back({32'(c), s});
  endtask

  // Repeats of a press entered at edge t_in, key released (raw) at edge t_rel:
  // a repeat at edge e needs the synchronized level still low, so e <= t_rel+1.
  task automatic exp_repeats(input int t_in, input int t_rel, input logic [3:0] m);
`ifdef KEY_DEBOUNCE_REPEAT_EN
    for (int t = t_in + RD; t <= t_rel + 1; t += RP) exp_pulse(t, m, 4'b0000);
`else
    if (t_in > t_rel) exp_pulse(t_in, m, 4'b0000);  // never true for the call sites
`endif
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [39:0] e;
    logic [35:0] s;
    if (st_q.size() != 0 && int'(st_q[0][35:4]) == cyc) begin
      s = st_q.pop_front();
      checks++;
      if (key_state !== s[3:0]) begin
        errors++;
        $display("FAIL key_state cyc=%0d got=%b exp=%b", cyc, key_state, s[3:0]);
      end
    end
    while (exp_q.size() != 0 && int'(exp_q[0][39:8]) < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_pulse cyc=%0d got=none exp_cyc=%0d press=%b release=%b",
               cyc, int'(e[39:8]), e[7:4], e[3:0]);
    end
    if ((key_press | key_release) !== 4'b0000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d press=%b release=%b exp=none",
                 cyc, key_press, key_release);
      end else begin
        e = exp_q.pop_front();
        if ({32'(cyc), key_press, key_release} !== e) begin
          errors++;
          $display("FAIL pulse cyc=%0d press=%b release=%b exp_cyc=%0d exp_press=%b exp_release=%b",
                   cyc, key_press, key_release, int'(e[39:8]), e[7:4], e[3:0]);
        end
      end
      checks++;
      if ((key_press & key_release) !== 4'b0000) begin
        errors++;
        $display("FAIL press_release_overlap cyc=%0d press=%b release=%b exp_overlap=0000",
                 cyc, key_press, key_release);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Level checks, hand-computed, in cycle order.
    exp_state(1,   4'b0000);
    exp_state(5,   4'b0000);
    exp_state(19,  4'b0000);
    exp_state(20,  4'b0001);
    exp_state(45,  4'b0001);
    exp_state(70,  4'b0001);
    exp_state(109, 4'b0001);
    exp_state(110, 4'b0000);
    exp_state(139, 4'b0000);
    exp_state(140, 4'b1111);
    exp_state(169, 4'b1111);
    exp_state(170, 4'b0000);
    exp_state(204, 4'b0000);
    exp_state(206, 4'b0000);
    exp_state(218, 4'b0000);
    exp_state(219, 4'b0100);
    exp_state(239, 4'b0100);
    exp_state(240, 4'b0000);

    #1 rst_n = 1'b0;
    goto(3);
    rst_n = 1'b1;

    // Single press on KEY[0] at edge 10, held until edge 100.
    goto(10);
    key[0] = 1'b0;
    exp_pulse(10 + LAT, 4'b0001, 4'b0000);
    exp_repeats(10 + LAT, 100, 4'b0001);

    // Bounce train on KEY[1]: 5 low, 3 high, four times; nothing comes out.
    for (int r = 0; r < 4; r++) begin
      goto(30 + 8 * r);
      key[1] = 1'b0;
      goto(35 + 8 * r);
      key[1] = 1'b1;
    end

    // Release KEY[0].
    goto(100);
    key[0] = 1'b1;
    exp_pulse(100 + LAT, 4'b0000, 4'b0001);

    // All keys together.
    goto(130);
    key = 4'b0000;
    exp_pulse(130 + LAT, 4'b1111, 4'b0000);
    exp_repeats(130 + LAT, 160, 4'b1111);
    goto(160);
    key = 4'b1111;
    exp_pulse(160 + LAT, 4'b0000, 4'b1111);

    // Reset in the middle of a WAIT_DOWN window on KEY[2]; key stays held,
    // so it is re-debounced from the first edge after reset release (209).
    goto(200);
    key = 4'b1011;
    exp_pulse(209 + LAT, 4'b0100, 4'b0000);
    goto(205);
    rst_n = 1'b0;
    goto(209);
    rst_n = 1'b1;
    goto(230);
    key = 4'b1111;
    exp_repeats(209 + LAT, 230, 4'b0100);
    exp_pulse(230 + LAT, 4'b0000, 4'b0100);

    goto(260);
    checks++;
    if (exp_q.size() != 0 || st_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations pulses=%0d states=%0d exp=0/0", exp_q.size(), st_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
